cpm_bnk_rsp_router: RTL and testbench
=====================================

Name: cpm_bnk_rsp_router

Overview:
- Return path of the CPM multi-input bank arbiter.
- The arbiter grants each bank to at most one requester per cycle. This block tracks those grants through the fixed bank read latency and steers each bank's read data back to the requester that was granted.
- Each requester has a small response FIFO with ready/valid backpressure.
- Per-requester credit outputs feed back to the arbiter request masks so the FIFOs never overflow.

Parameters:
REQ_DW, 4, number of requester ports
BNK_DW, 4, number of banks
REQ_AW, $clog2(REQ_DW), requester index width
BNK_AW, $clog2(BNK_DW), bank index width
DAT_DW, 16, bank read data width
RD_LAT, 1, bank read latency in cycles from grant to BNK_RDAT valid (1..4)
FIFO_DEP, 4, entries per requester response FIFO (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
GNT_VLD  in  BNK_DW  bank b accessed this cycle
GNT_IDX  in  BNK_DW*REQ_AW  requester index served by bank b, field b at [b*REQ_AW +: REQ_AW]
BNK_RDAT  in  BNK_DW*DAT_DW  bank read data, valid RD_LAT cycles after the matching GNT_VLD
RSP_VLD  out  REQ_DW  response available for requester r
RSP_RDY  in  REQ_DW  requester r accepts response
RSP_DAT  out  REQ_DW*DAT_DW  response data per requester
RSP_BNK  out  REQ_DW*BNK_AW  source bank of the response
REQ_CRD  out  REQ_DW  1 = requester r may be granted this cycle
ERR_OVF  out  1  sticky: push into a full FIFO was dropped
ERR_COL  out  1  sticky: two banks returned to the same requester in one cycle

Behaviour:
- Reset: one clock and a synchronous active-low rst_n, sampled on the clk rising edge. All state clears on reset: tag pipe, FIFOs, pointers, inflight counters and error flags.
- Reset output values: RSP_VLD=0, RSP_DAT=0, RSP_BNK=0, ERR_OVF=0, ERR_COL=0, REQ_CRD=all 1.
- Tag pipe: RD_LAT register stages, each holding {vld[BNK_DW], idx[BNK_DW*REQ_AW]}.
  - Stage 0 captures GNT_VLD/GNT_IDX.
  - The last stage aligns with BNK_RDAT.
  - Stages shift unconditionally; the pipe never stalls.
- Return decode at the last stage: for each requester r, hit_r = OR over banks b of (vld[b] && idx[b]==r).
  - If several banks hit the same r, the lowest bank index wins, the others are dropped, and ERR_COL is set.
- Push: on hit_r, write {BNK_RDAT[b], b} into FIFO r.
  - If FIFO r is full and not popping in the same cycle, drop the push and set ERR_OVF.
  - Push and pop in the same cycle are allowed when full; occupancy is unchanged.
- FIFO read is first-word-fall-through.
  - RSP_VLD[r] = not empty.
  - RSP_DAT/RSP_BNK show the head entry.
  - Pop occurs on RSP_VLD[r] && RSP_RDY[r].
  - RSP_DAT/RSP_BNK hold their value while RSP_VLD=1 and RSP_RDY=0.
- Pointers are BNK_AW-independent, $clog2(FIFO_DEP)+1 bits, and wrap naturally.
- Latency: grant at cycle t -> BNK_RDAT sampled at t+RD_LAT -> RSP_VLD at t+RD_LAT+1 (FIFO previously empty).
- Inflight counter per requester, width $clog2(FIFO_DEP)+1:
  - +1 on a grant (any GNT_VLD[b] with GNT_IDX[b]==r).
  - -1 on a push attempt at the pipe end.
  - Both in the same cycle: unchanged.
- REQ_CRD[r] = (inflight_r + occupancy_r) < FIFO_DEP. It is combinational from registers only, with no path from GNT_* or RSP_RDY.
- The arbiter must not grant r while REQ_CRD[r]=0. If it does, the block stays functional and the overflow is flagged via ERR_OVF at push time.
- Error flags clear only on reset.
- Reset mid-operation: in-flight tags and FIFO contents are discarded, and BNK_RDAT arriving after reset is ignored.

Optional Feature:
- Macro: CPM_RSP_BYPASS_EN.
- Defined:
  - When FIFO r is empty and hit_r is set, the bank data is driven combinationally onto RSP_DAT/RSP_BNK with RSP_VLD[r]=1 in the same cycle, giving latency t+RD_LAT.
  - If RSP_RDY[r]=1 that cycle, the entry is consumed and not written.
  - Otherwise it is written normally and held.
- Undefined: all responses pass through the FIFO registers; latency is t+RD_LAT+1 and there is no combinational BNK_RDAT->RSP path.

Test Plan:
- Single return (macro off), RD_LAT=1: reset, then GNT_VLD=4'b0100, GNT_IDX bank2=1, BNK_RDAT bank2=16'hA5A5 one cycle later -> RSP_VLD=4'b0010 two cycles after the grant, RSP_DAT[1]=16'hA5A5, RSP_BNK[1]=2.
- All four banks in one cycle, bank b granted to requester 3-b, data 16'h100+b -> all RSP_VLD set in the same cycle; requester 0 gets 16'h103 with bank 3.
- Credit: requester 0 granted 4 times with RSP_RDY=0 -> REQ_CRD[0] drops to 0 after the 4th grant. One pop -> REQ_CRD[0]=1 the next cycle. Data order preserved.
- Overflow/collision: force a 5th grant to a full requester 2 -> ERR_OVF=1, FIFO contents unchanged. Grant banks 0 and 3 both to requester 1 -> bank 0 data kept, ERR_COL=1.
- Backpressure hold and reset: RSP_RDY toggles 1,0,1 -> RSP_DAT stable while stalled, no loss. Assert rst_n=0 with entries queued -> RSP_VLD=0, REQ_CRD=4'b1111, flags 0 the next cycle.
- CPM_RSP_BYPASS_EN defined, empty FIFO, RSP_RDY=1 -> RSP_VLD asserted in the cycle BNK_RDAT is valid, FIFO stays empty.

Source files
------------

// File: rtl/cpm_bnk_rsp_router_if.sv
// ============================================================================
// Module      : cpm_bnk_rsp_router_if
// Description : Grant/read-data/response bundle of the CPM bank return path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpm_bnk_rsp_router_if #(
  parameter int REQ_DW = 4,
  parameter int BNK_DW = 4,
  parameter int DAT_DW = 16,
  parameter int REQ_AW = $clog2(REQ_DW),
  parameter int BNK_AW = $clog2(BNK_DW)
);
  logic [BNK_DW-1:0]        i_gnt_vld;
  logic [BNK_DW*REQ_AW-1:0] i_gnt_idx;
  logic [BNK_DW*DAT_DW-1:0] i_bnk_rdat;
  logic [REQ_DW-1:0]        i_rsp_rdy;
  logic [REQ_DW-1:0]        o_rsp_vld;
  logic [REQ_DW*DAT_DW-1:0] o_rsp_dat;
  logic [REQ_DW*BNK_AW-1:0] o_rsp_bnk;
  logic [REQ_DW-1:0]        o_req_crd;
  logic                     o_err_ovf;
  logic                     o_err_col;

  modport slave (
    input  i_gnt_vld, i_gnt_idx, i_bnk_rdat, i_rsp_rdy,
    output o_rsp_vld, o_rsp_dat, o_rsp_bnk, o_req_crd, o_err_ovf, o_err_col
  );

  modport master (
    output i_gnt_vld, i_gnt_idx, i_bnk_rdat, i_rsp_rdy,
    input  o_rsp_vld, o_rsp_dat, o_rsp_bnk, o_req_crd, o_err_ovf, o_err_col
  );
endinterface

`default_nettype wire

// File: rtl/cpm_bnk_rsp_router.sv
// ============================================================================
// Module      : cpm_bnk_rsp_router
// Description : Steers bank read data to granted requesters via per-requester
//               FWFT FIFOs with credits. Optional macro CPM_RSP_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpm_bnk_rsp_router #(
  parameter int REQ_DW   = 4,
  parameter int BNK_DW   = 4,
  parameter int REQ_AW   = $clog2(REQ_DW),
  parameter int BNK_AW   = $clog2(BNK_DW),
  parameter int DAT_DW   = 16,
  parameter int RD_LAT   = 1,
  parameter int FIFO_DEP = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cpm_bnk_rsp_router_if.slave  bus
);

  localparam int PW = $clog2(FIFO_DEP) + 1;
  localparam int EW = DAT_DW + BNK_AW;

  logic [BNK_DW-1:0]        r_tag_vld [RD_LAT];
  logic [BNK_DW*REQ_AW-1:0] r_tag_idx [RD_LAT];
  logic [BNK_DW-1:0]        w_end_vld;
  logic [BNK_DW*REQ_AW-1:0] w_end_idx;

  logic [REQ_DW-1:0] w_hit;
  logic [REQ_DW-1:0] w_gnt;
  logic              w_col;
  logic [BNK_AW-1:0] w_src     [REQ_DW];
  logic [DAT_DW-1:0] w_src_dat [REQ_DW];
  logic [REQ_DW-1:0] w_ovf_vec;

  logic r_err_ovf;
  logic r_err_col;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        r_tag_vld[s] <= '0;
        r_tag_idx[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= bus.i_gnt_vld;
      r_tag_idx[0] <= bus.i_gnt_idx;
      for (int s = 1; s < RD_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end
    end
  end

  assign w_end_vld = r_tag_vld[RD_LAT-1];
  assign w_end_idx = r_tag_idx[RD_LAT-1];

  // Banks scanned high to low so the lowest hitting bank is the one retained.
  always_comb begin
    w_hit = '0;
    w_gnt = '0;
    w_col = 1'b0;
    for (int r = 0; r < REQ_DW; r++) begin
      w_src[r]     = '0;
      w_src_dat[r] = '0;
      for (int b = BNK_DW - 1; b >= 0; b--) begin
        if (w_end_vld[b] && (w_end_idx[b*REQ_AW +: REQ_AW] == REQ_AW'(r))) begin
          if (w_hit[r]) begin
            w_col = 1'b1;
          end
          w_hit[r]     = 1'b1;
          w_src[r]     = BNK_AW'(b);
          w_src_dat[r] = bus.i_bnk_rdat[b*DAT_DW +: DAT_DW];
        end
        if (bus.i_gnt_vld[b] && (bus.i_gnt_idx[b*REQ_AW +: REQ_AW] == REQ_AW'(r))) begin
          w_gnt[r] = 1'b1;
        end
      end
    end
  end

  for (genvar gr = 0; gr < REQ_DW; gr++) begin : g_req
    logic [EW-1:0] r_mem [FIFO_DEP];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_inf;
    logic [PW-1:0] w_occ;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf;
    logic          w_vld;
    logic [EW-1:0] w_head;
    logic [EW-1:0] w_out;
    logic [PW:0]   w_crd_sum;

    assign w_occ     = r_wr - r_rd;
    assign w_empty   = (w_occ == '0);
    assign w_full    = (w_occ == PW'(FIFO_DEP));
    assign w_head    = r_mem[r_rd[PW-2:0]];
    assign w_crd_sum = {1'b0, r_inf} + {1'b0, w_occ};

    always_comb begin
      w_vld  = !w_empty;
      w_out  = w_head;
      w_pop  = !w_empty && bus.i_rsp_rdy[gr];
      w_push = w_hit[gr] && (!w_full || w_pop);
`ifdef CPM_RSP_BYPASS_EN
      // Empty FIFO: present the bank data directly; store only if not taken.
      if (w_empty && w_hit[gr]) begin
        w_vld  = 1'b1;
        w_out  = {w_src_dat[gr], w_src[gr]};
        w_push = !bus.i_rsp_rdy[gr];
      end
`endif
      w_ovf = w_hit[gr] && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wr[PW-2:0]] <= {w_src_dat[gr], w_src[gr]};
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_inf <= '0;
      end else begin
        if (w_push) begin
          r_wr <= r_wr + 1'b1;
        end
        if (w_pop) begin
          r_rd <= r_rd + 1'b1;
        end
        // Saturate so a misbehaving arbiter cannot wrap the count.
        case ({w_gnt[gr], w_hit[gr]})
          2'b10:   if (r_inf != '1) r_inf <= r_inf + 1'b1;
          2'b01:   if (r_inf != '0) r_inf <= r_inf - 1'b1;
          default: ;
        endcase
      end
    end

    assign w_ovf_vec[gr]                        = w_ovf;
    assign bus.o_rsp_vld[gr]                    = w_vld;
    assign bus.o_rsp_dat[gr*DAT_DW +: DAT_DW]   = w_vld ? w_out[EW-1:BNK_AW] : '0;
    assign bus.o_rsp_bnk[gr*BNK_AW +: BNK_AW]   = w_vld ? w_out[BNK_AW-1:0] : '0;
    assign bus.o_req_crd[gr]                    = (w_crd_sum < (PW+1)'(FIFO_DEP));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_ovf <= 1'b0;
      r_err_col <= 1'b0;
    end else begin
      if (|w_ovf_vec) begin
        r_err_ovf <= 1'b1;
      end
      if (w_col) begin
        r_err_col <= 1'b1;
      end
    end
  end

  assign bus.o_err_ovf = r_err_ovf;
  assign bus.o_err_col = r_err_col;

endmodule

`default_nettype wire

// File: tb/tb_cpm_bnk_rsp_router.sv
// ============================================================================
// Module      : tb_cpm_bnk_rsp_router
// Description : Directed bench for cpm_bnk_rsp_router (RD_LAT=1, 4x4, 16b).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpm_bnk_rsp_router;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  cpm_bnk_rsp_router_if bus_if ();

  cpm_bnk_rsp_router dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] dat(input int r);
    return bus_if.o_rsp_dat[r*16 +: 16];
  endfunction

  function automatic logic [1:0] bnk(input int r);
    return bus_if.o_rsp_bnk[r*2 +: 2];
  endfunction

  // Grant in one cycle, return data in the next (RD_LAT=1).
  task automatic grant(input logic [3:0] v, input logic [7:0] idx, input logic [63:0] d);
    bus_if.i_gnt_vld  = v;
    bus_if.i_gnt_idx  = idx;
    step();
    bus_if.i_gnt_vld  = '0;
    bus_if.i_gnt_idx  = '0;
    bus_if.i_bnk_rdat = d;
    step();
    bus_if.i_bnk_rdat = '0;
  endtask

  task automatic pop(input logic [3:0] m);
    bus_if.i_rsp_rdy = m;
    step();
    bus_if.i_rsp_rdy = '0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.i_gnt_vld  = '0;
    bus_if.i_gnt_idx  = '0;
    bus_if.i_bnk_rdat = '0;
    bus_if.i_rsp_rdy  = '0;
    step();
    step();
    check_eq("rst_vld", bus_if.o_rsp_vld, 4'b0000);
    check_eq("rst_dat", bus_if.o_rsp_dat, 64'h0);
    check_eq("rst_bnk", bus_if.o_rsp_bnk, 8'h0);
    check_eq("rst_crd", bus_if.o_req_crd, 4'b1111);
    check_eq("rst_ovf", bus_if.o_err_ovf, 1'b0);
    check_eq("rst_col", bus_if.o_err_col, 1'b0);
    rst_n = 1'b1;
    step();

    // Single return: bank 2 -> requester 1
    bus_if.i_gnt_vld = 4'b0100;
    bus_if.i_gnt_idx = 8'h10;
    step();
    bus_if.i_gnt_vld  = '0;
    bus_if.i_gnt_idx  = '0;
    bus_if.i_bnk_rdat = 64'h0000_A5A5_0000_0000;
`ifndef CPM_RSP_BYPASS_EN
    check_eq("single_early_vld", bus_if.o_rsp_vld, 4'b0000);
`endif
    check_eq("single_inflight_crd", bus_if.o_req_crd, 4'b1111);
    step();
    bus_if.i_bnk_rdat = '0;
    check_eq("single_vld", bus_if.o_rsp_vld, 4'b0010);
    check_eq("single_dat", dat(1), 16'hA5A5);
    check_eq("single_bnk", bnk(1), 2'd2);
    pop(4'b0010);
    check_eq("single_drained", bus_if.o_rsp_vld, 4'b0000);

    // All four banks, bank b -> requester 3-b, data 0x100+b
    grant(4'b1111, 8'h1B, 64'h0103_0102_0101_0100);
    check_eq("all_vld", bus_if.o_rsp_vld, 4'b1111);
    check_eq("all_dat0", dat(0), 16'h0103);
    check_eq("all_bnk0", bnk(0), 2'd3);
    check_eq("all_dat3", dat(3), 16'h0100);
    check_eq("all_bnk3", bnk(3), 2'd0);
    pop(4'b1111);
    check_eq("all_drained", bus_if.o_rsp_vld, 4'b0000);

    // Credit: four pipelined grants to requester 0 with RSP_RDY low
    for (int i = 0; i < 4; i++) begin
      bus_if.i_gnt_vld  = 4'b0001;
      bus_if.i_gnt_idx  = 8'h00;
      bus_if.i_bnk_rdat = (i == 0) ? 64'h0 : {48'h0, 16'hC000 + 16'(i - 1)};
      step();
      if (i == 2) check_eq("crd_after3", bus_if.o_req_crd[0], 1'b1);
      if (i == 3) check_eq("crd_after4", bus_if.o_req_crd[0], 1'b0);
    end
    bus_if.i_gnt_vld  = '0;
    bus_if.i_bnk_rdat = {48'h0, 16'hC003};
    step();
    bus_if.i_bnk_rdat = '0;
    check_eq("crd_full", bus_if.o_req_crd[0], 1'b0);
    check_eq("crd_head", dat(0), 16'hC000);
    pop(4'b0001);
    check_eq("crd_regain", bus_if.o_req_crd[0], 1'b1);
    for (int i = 1; i < 4; i++) begin
      check_eq("crd_order", dat(0), 16'hC000 + 16'(i));
      pop(4'b0001);
    end
    check_eq("crd_empty", bus_if.o_rsp_vld[0], 1'b0);

    // Overflow: fill requester 2 through bank 1, then force a fifth grant
    for (int i = 0; i < 4; i++) begin
      grant(4'b0010, 8'h08, {32'h0, 16'hE000 + 16'(i), 16'h0});
    end
    check_eq("ovf_crd0", bus_if.o_req_crd[2], 1'b0);
    check_eq("ovf_pre", bus_if.o_err_ovf, 1'b0);
    grant(4'b0010, 8'h08, {32'h0, 16'hEEEE, 16'h0});
    check_eq("ovf_flag", bus_if.o_err_ovf, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_eq("ovf_content", dat(2), 16'hE000 + 16'(i));
      pop(4'b0100);
    end
    check_eq("ovf_empty", bus_if.o_rsp_vld[2], 1'b0);

    // Collision: banks 0 and 3 both returning to requester 1
    check_eq("col_pre", bus_if.o_err_col, 1'b0);
    grant(4'b1001, 8'h41, 64'h3333_0000_0000_1111);
    check_eq("col_flag", bus_if.o_err_col, 1'b1);
    check_eq("col_vld", bus_if.o_rsp_vld, 4'b0010);
    check_eq("col_dat", dat(1), 16'h1111);
    check_eq("col_bnk", bnk(1), 2'd0);
    pop(4'b0010);
    check_eq("col_dropped", bus_if.o_rsp_vld, 4'b0000);
    check_eq("col_crd", bus_if.o_req_crd, 4'b1111);

    // Backpressure: two entries on requester 3, RSP_RDY 1,0,1
    grant(4'b0100, 8'h30, 64'h0000_B000_0000_0000);
    grant(4'b0100, 8'h30, 64'h0000_B001_0000_0000);
    check_eq("bp_head0", dat(3), 16'hB000);
    bus_if.i_rsp_rdy = 4'b1000;
    step();
    check_eq("bp_head1", dat(3), 16'hB001);
    bus_if.i_rsp_rdy = 4'b0000;
    step();
    check_eq("bp_hold_dat", dat(3), 16'hB001);
    check_eq("bp_hold_vld", bus_if.o_rsp_vld[3], 1'b1);
    bus_if.i_rsp_rdy = 4'b1000;
    step();
    bus_if.i_rsp_rdy = 4'b0000;
    check_eq("bp_drained", bus_if.o_rsp_vld[3], 1'b0);

    // Reset mid-operation: queued entry, one grant in flight, sticky flags set
    grant(4'b0001, 8'h00, 64'h0000_0000_0000_7777);
    bus_if.i_gnt_vld = 4'b0001;
    bus_if.i_gnt_idx = 8'h01;
    step();
    bus_if.i_gnt_vld = '0;
    bus_if.i_gnt_idx = '0;
    rst_n = 1'b0;
    step();
    check_eq("mrst_vld", bus_if.o_rsp_vld, 4'b0000);
    check_eq("mrst_crd", bus_if.o_req_crd, 4'b1111);
    check_eq("mrst_ovf", bus_if.o_err_ovf, 1'b0);
    check_eq("mrst_col", bus_if.o_err_col, 1'b0);
    check_eq("mrst_dat", bus_if.o_rsp_dat, 64'h0);
    rst_n = 1'b1;
    bus_if.i_bnk_rdat = 64'h0000_0000_0000_DEAD;
    step();
    bus_if.i_bnk_rdat = '0;
    step();
    check_eq("mrst_late_vld", bus_if.o_rsp_vld, 4'b0000);
    check_eq("mrst_late_crd", bus_if.o_req_crd, 4'b1111);

`ifdef CPM_RSP_BYPASS_EN
    // Bypass: empty FIFO, ready requester takes data in the return cycle
    bus_if.i_rsp_rdy = 4'b0010;
    bus_if.i_gnt_vld = 4'b0100;
    bus_if.i_gnt_idx = 8'h10;
    step();
    bus_if.i_gnt_vld  = '0;
    bus_if.i_gnt_idx  = '0;
    bus_if.i_bnk_rdat = 64'h0000_5A5A_0000_0000;
    #1;
    check_eq("byp_vld", bus_if.o_rsp_vld, 4'b0010);
    check_eq("byp_dat", dat(1), 16'h5A5A);
    check_eq("byp_bnk", bnk(1), 2'd2);
    step();
    bus_if.i_bnk_rdat = '0;
    bus_if.i_rsp_rdy  = '0;
    check_eq("byp_empty", bus_if.o_rsp_vld, 4'b0000);
    check_eq("byp_crd", bus_if.o_req_crd, 4'b1111);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
